// File: rtl/micropop_pkg.sv
// Shared types and constants for the micropop fetch/decode slice.
// FETCH_DECODE_ILLEGAL_TRAP_EN turns illegal opcodes and r15 writes into a halting trap.
package micropop_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LI   = 4'h6,
        OP_JMP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_t;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int TARGET_MSB = 11;
    localparam int TARGET_LSB = 8;
    localparam int SRC1_MSB   = 7;
    localparam int SRC1_LSB   = 4;
    localparam int SRC2_MSB   = 3;
    localparam int SRC2_LSB   = 0;

    localparam logic [3:0] ALU_PASS = 4'h6;
    localparam logic [3:0] REG_IP   = 4'hF;

`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // LI immediate: sign-extend the low byte.
    function automatic logic [15:0] sext_imm8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

    // JMP offset: sign-extended 12-bit word offset converted to bytes.
    function automatic logic [15:0] jump_offset(input logic [11:0] value);
        return {{3{value[11]}}, value, 1'b0};
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational decode of one 16-bit micropop instruction into
// register indices, strobes, ALU select, immediate and illegal flags.
module instruction_decoder
    import micropop_pkg::*;
(
    input  logic [15:0] instruction,
    output logic [3:0]  source1_address,
    output logic [3:0]  source2_address,
    output logic [3:0]  target_address,
    output logic        write_enable,
    output logic        jump,
    output logic        use_immediate,
    output logic        halt,
    output logic        illegal,
    output logic [3:0]  alu_op,
    output logic [15:0] immediate
);

    opcode_t opcode_s;
    logic    wants_write_s;
    logic    illegal_opcode_s;
    logic    ip_write_s;

    assign source1_address = instruction[SRC1_MSB:SRC1_LSB];
    assign source2_address = instruction[SRC2_MSB:SRC2_LSB];
    assign target_address  = instruction[TARGET_MSB:TARGET_LSB];

    // Opcode decode into strobes, ALU select and immediate.
    always_comb begin
        opcode_s         = opcode_t'(instruction[OPCODE_MSB:OPCODE_LSB]);
        wants_write_s    = 1'b0;
        jump             = 1'b0;
        use_immediate    = 1'b0;
        halt             = 1'b0;
        illegal_opcode_s = 1'b0;
        alu_op           = 4'h0;
        immediate        = 16'h0000;
        case (opcode_s)
            OP_NOP: begin
                wants_write_s = 1'b0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                wants_write_s = 1'b1;
                alu_op        = instruction[OPCODE_MSB:OPCODE_LSB];
            end
            OP_LI: begin
                wants_write_s = 1'b1;
                use_immediate = 1'b1;
                alu_op        = ALU_PASS;
                immediate     = sext_imm8(instruction[7:0]);
            end
            OP_JMP: begin
                jump      = 1'b1;
                immediate = jump_offset(instruction[11:0]);
            end
            OP_HALT: begin
                halt = 1'b1;
            end
            default: begin
                illegal_opcode_s = 1'b1;
            end
        endcase
    end

    // r15 is only ever updated by the commit path, never as a write target.
    assign ip_write_s   = wants_write_s & (target_address == REG_IP);
    assign write_enable = wants_write_s & ~ip_write_s;
    assign illegal      = illegal_opcode_s | ip_write_s;

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode sequencer for the micropop core: fetches one instruction per pass,
// commits it to the register bank. Build option: FETCH_DECODE_ILLEGAL_TRAP_EN.
module fetch_decode
    import micropop_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] InstructionPointer,
    output logic        FetchValid,
    output logic [15:0] FetchAddress,
    input  logic        FetchReady,
    input  logic        ResponseValid,
    input  logic [15:0] ResponseData,
    output logic        BankEnable,
    output logic [3:0]  Source1Address,
    output logic [3:0]  Source2Address,
    output logic [3:0]  TargetAddress,
    output logic        TargetWriteEnable,
    output logic        Jump,
    output logic [3:0]  AluOp,
    output logic        UseImmediate,
    output logic [15:0] Immediate,
    output logic        Halted,
    output logic        IllegalInstruction
);

    fetch_state_t state_r;
    logic [15:0]  ir_r;
    logic [15:0]  ir_d_s;
    logic         fetch_valid_r;
    logic         trap_s;

    logic [3:0]   dec_src1_s;
    logic [3:0]   dec_src2_s;
    logic [3:0]   dec_target_s;
    logic         dec_write_s;
    logic         dec_jump_s;
    logic         dec_use_imm_s;
    logic         dec_halt_s;
    logic         dec_illegal_s;
    logic [3:0]   dec_alu_op_s;
    logic [15:0]  dec_imm_s;

    // Decode the word about to land in the instruction register so the
    // decoded outputs can be registered on the same edge that closes WAIT.
    assign ir_d_s = ((state_r == ST_WAIT) && ResponseValid) ? ResponseData : ir_r;

    instruction_decoder u_decoder (
        .instruction     (ir_d_s),
        .source1_address (dec_src1_s),
        .source2_address (dec_src2_s),
        .target_address  (dec_target_s),
        .write_enable    (dec_write_s),
        .jump            (dec_jump_s),
        .use_immediate   (dec_use_imm_s),
        .halt            (dec_halt_s),
        .illegal         (dec_illegal_s),
        .alu_op          (dec_alu_op_s),
        .immediate       (dec_imm_s)
    );

    assign trap_s = TRAP_EN & dec_illegal_s;

    // r15 is read live: it changes on the edge closing EXECUTE, so the next
    // REQUEST already presents the advanced pointer.
    assign FetchValid   = fetch_valid_r;
    assign FetchAddress = fetch_valid_r ? InstructionPointer : 16'h0000;

    // Sequencing FSM with registered decode outputs and commit strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r            <= ST_IDLE;
            ir_r               <= 16'h0000;
            fetch_valid_r      <= 1'b0;
            BankEnable         <= 1'b0;
            Source1Address     <= 4'h0;
            Source2Address     <= 4'h0;
            TargetAddress      <= 4'h0;
            TargetWriteEnable  <= 1'b0;
            Jump               <= 1'b0;
            AluOp              <= 4'h0;
            UseImmediate       <= 1'b0;
            Immediate          <= 16'h0000;
            Halted             <= 1'b0;
            IllegalInstruction <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_REQUEST;
                    fetch_valid_r <= 1'b1;
                end
                ST_REQUEST: begin
                    if (FetchReady) begin
                        state_r       <= ST_WAIT;
                        fetch_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ResponseValid) begin
                        state_r           <= ST_EXECUTE;
                        ir_r              <= ResponseData;
                        Source1Address    <= dec_src1_s;
                        Source2Address    <= dec_src2_s;
                        TargetAddress     <= dec_target_s;
                        AluOp             <= dec_alu_op_s;
                        Immediate         <= dec_imm_s;
                        BankEnable        <= ~trap_s;
                        TargetWriteEnable <= dec_write_s & ~trap_s;
                        Jump              <= dec_jump_s & ~trap_s;
                        UseImmediate      <= dec_use_imm_s & ~trap_s;
                    end
                end
                ST_EXECUTE: begin
                    BankEnable        <= 1'b0;
                    TargetWriteEnable <= 1'b0;
                    Jump              <= 1'b0;
                    UseImmediate      <= 1'b0;
                    if (dec_halt_s || trap_s) begin
                        state_r            <= ST_HALTED;
                        Halted             <= 1'b1;
                        IllegalInstruction <= IllegalInstruction | trap_s;
                    end else begin
                        state_r       <= ST_REQUEST;
                        fetch_valid_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r           <= ST_IDLE;
                    fetch_valid_r     <= 1'b0;
                    BankEnable        <= 1'b0;
                    TargetWriteEnable <= 1'b0;
                    Jump              <= 1'b0;
                    UseImmediate      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with a small r15 bank model.
module tb_fetch_decode;

    logic        Clock;
    logic        Reset;
    logic [15:0] ip;
    logic        FetchValid;
    logic [15:0] FetchAddress;
    logic        FetchReady;
    logic        ResponseValid;
    logic [15:0] ResponseData;
    logic        BankEnable;
    logic [3:0]  Source1Address;
    logic [3:0]  Source2Address;
    logic [3:0]  TargetAddress;
    logic        TargetWriteEnable;
    logic        Jump;
    logic [3:0]  AluOp;
    logic        UseImmediate;
    logic [15:0] Immediate;
    logic        Halted;
    logic        IllegalInstruction;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_decode dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .InstructionPointer (ip),
        .FetchValid         (FetchValid),
        .FetchAddress       (FetchAddress),
        .FetchReady         (FetchReady),
        .ResponseValid      (ResponseValid),
        .ResponseData       (ResponseData),
        .BankEnable         (BankEnable),
        .Source1Address     (Source1Address),
        .Source2Address     (Source2Address),
        .TargetAddress      (TargetAddress),
        .TargetWriteEnable  (TargetWriteEnable),
        .Jump               (Jump),
        .AluOp              (AluOp),
        .UseImmediate       (UseImmediate),
        .Immediate          (Immediate),
        .Halted             (Halted),
        .IllegalInstruction (IllegalInstruction)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the bank model commits r15 on the edge closing a BankEnable cycle.
    task automatic tick();
        logic        be;
        logic        j;
        logic [15:0] im;
        be = BankEnable;
        j  = Jump;
        im = Immediate;
        @(posedge Clock);
        if (be === 1'b1) ip = (j === 1'b1) ? ip + im : ip + 16'd2;
        #1;
    endtask

    // Called in REQUEST; returns sampled in EXECUTE of the given instruction.
    task automatic exec(input logic [15:0] instr, input int ready_delay, input int resp_delay);
        FetchReady = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            check("stall_valid", {15'd0, FetchValid}, 16'd1);
            check("stall_addr", FetchAddress, ip);
            tick();
        end
        FetchReady    = 1'b1;
        ResponseValid = 1'b1;
        ResponseData  = 16'hF000;
        check("req_valid", {15'd0, FetchValid}, 16'd1);
        check("req_addr", FetchAddress, ip);
        tick();
        FetchReady    = 1'b0;
        ResponseValid = 1'b0;
        check("wait_valid", {15'd0, FetchValid}, 16'd0);
        for (int i = 0; i < resp_delay; i++) begin
            check("wait_no_commit", {15'd0, BankEnable}, 16'd0);
            tick();
        end
        ResponseValid = 1'b1;
        ResponseData  = instr;
        tick();
        ResponseValid = 1'b0;
        ResponseData  = 16'h0000;
    endtask

    initial begin
        Reset         = 1'b1;
        ip            = 16'h0000;
        FetchReady    = 1'b0;
        ResponseValid = 1'b0;
        ResponseData  = 16'h0000;
        tick();
        tick();
        check("rst_valid", {15'd0, FetchValid}, 16'd0);
        check("rst_addr", FetchAddress, 16'h0000);
        check("rst_bank", {15'd0, BankEnable}, 16'd0);
        check("rst_halt", {14'd0, Halted, IllegalInstruction}, 16'd0);
        check("rst_imm", Immediate, 16'h0000);

        Reset = 1'b0;
        tick();
        // ADD r1, r2, r3 at IP 0
        exec(16'h1123, 0, 0);
        check("add_bank", {15'd0, BankEnable}, 16'd1);
        check("add_regs", {4'd0, TargetAddress, Source1Address, Source2Address}, 16'h0123);
        check("add_alu", {12'd0, AluOp}, 16'd1);
        check("add_strobes", {13'd0, TargetWriteEnable, Jump, UseImmediate}, 16'b100);
        tick();
        check("add_bank_off", {15'd0, BankEnable}, 16'd0);
        check("add_next_addr", FetchAddress, 16'h0002);

        // LI r4, 0xFE
        exec(16'h64FE, 0, 0);
        check("li_imm", Immediate, 16'hFFFE);
        check("li_strobes", {13'd0, TargetWriteEnable, Jump, UseImmediate}, 16'b101);
        check("li_target", {12'd0, TargetAddress}, 16'd4);
        check("li_alu", {12'd0, AluOp}, 16'd6);
        tick();

        // JMP +12 from IP 4, then JMP -4 from 0x0010
        exec(16'hE006, 0, 0);
        check("jmpf_imm", Immediate, 16'h000C);
        tick();
        check("jmpf_addr", FetchAddress, 16'h0010);
        exec(16'hEFFE, 0, 0);
        check("jmpb_jump", {15'd0, Jump}, 16'd1);
        check("jmpb_imm", Immediate, 16'hFFFC);
        check("jmpb_twe", {15'd0, TargetWriteEnable}, 16'd0);
        tick();
        check("jmpb_addr", FetchAddress, 16'h000C);

        // SUB r3 with memory stalls
        exec(16'h2345, 5, 4);
        check("slow_bank", {15'd0, BankEnable}, 16'd1);
        check("slow_alu", {12'd0, AluOp}, 16'd2);
        check("slow_target", {11'd0, TargetWriteEnable, TargetAddress}, 16'h0013);
        tick();
        check("slow_bank_off", {15'd0, BankEnable}, 16'd0);
        check("slow_next_addr", FetchAddress, 16'h000E);

        // NOP still commits
        exec(16'h0000, 0, 0);
        check("nop_strobes", {12'd0, BankEnable, TargetWriteEnable, Jump, UseImmediate}, 16'b1000);
        tick();
        check("nop_next_addr", FetchAddress, 16'h0010);

        // HALT
        exec(16'hF000, 0, 0);
        check("halt_bank", {15'd0, BankEnable}, 16'd1);
        tick();
        check("halt_flag", {15'd0, Halted}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            check("halt_quiet", {14'd0, FetchValid, BankEnable}, 16'd0);
            tick();
        end
        check("halt_ip", ip, 16'h0012);

        // Reset in the middle of WAIT, response arriving one cycle late
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        FetchReady = 1'b1;
        tick();
        FetchReady = 1'b0;
        check("mid_wait_valid", {15'd0, FetchValid}, 16'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_state", {14'd0, FetchValid, Halted}, 16'd0);
        ResponseValid = 1'b1;
        ResponseData  = 16'h64FE;
        tick();
        ResponseValid = 1'b0;
        check("late_resp_valid", {15'd0, FetchValid}, 16'd1);
        check("late_resp_addr", FetchAddress, 16'h0012);
        check("late_resp_bank", {15'd0, BankEnable}, 16'd0);

        // Illegal opcode 0x9
        exec(16'h9000, 0, 1);
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
        check("ill_bank", {15'd0, BankEnable}, 16'd0);
        tick();
        check("ill_flags", {14'd0, Halted, IllegalInstruction}, 16'b11);
        check("ill_valid", {15'd0, FetchValid}, 16'd0);
        check("ill_ip", ip, 16'h0012);
`else
        check("ill_strobes", {12'd0, BankEnable, TargetWriteEnable, Jump, UseImmediate}, 16'b1000);
        tick();
        check("ill_flags", {14'd0, Halted, IllegalInstruction}, 16'b00);
        check("ill_next_addr", FetchAddress, 16'h0014);
`endif

        // Write to r15: ADD r15, r1, r2
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_illegal_clr", {14'd0, Halted, IllegalInstruction}, 16'd0);
        tick();
        exec(16'h1F12, 0, 0);
        check("r15_twe", {15'd0, TargetWriteEnable}, 16'd0);
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
        check("r15_bank", {15'd0, BankEnable}, 16'd0);
        tick();
        check("r15_flags", {14'd0, Halted, IllegalInstruction}, 16'b11);
`else
        check("r15_bank", {15'd0, BankEnable}, 16'd1);
        tick();
        check("r15_flags", {14'd0, Halted, IllegalInstruction}, 16'b00);
        check("r15_next_addr", FetchAddress, 16'h0016);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
